// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_responder data-memory target.
package dmem_pkg;

  localparam int unsigned DATA_W      = 64;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_BYTES  = 8;
  localparam int unsigned OFFSET_BITS = 3;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Non-address part of a request, latched at acceptance.
  typedef struct packed {
    logic                  write;
    logic [DATA_W-1:0]     wdata;
    logic [WORD_BYTES-1:0] wstrb;
  } wr_req_t;

  // Replace the bytes of old_word selected by strb with those of new_word.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0]     old_word,
                                                   input logic [DATA_W-1:0]     new_word,
                                                   input logic [WORD_BYTES-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      if (strb[i]) res[BYTE_W*i +: BYTE_W] = new_word[BYTE_W*i +: BYTE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM stage (master) and dmem_responder (slave).
interface dmem_responder_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [WORD_BYTES-1:0] req_wstrb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word RAM with per-byte write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  access,
  input  logic                  rd,
  input  logic [WORD_BYTES-1:0] wbe,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (access && (wbe != '0)) mem[idx] <= byte_merge(mem[idx], wdata, wbe);
  end

  // Read data is zero for any access that is not a load, and holds between accesses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    rdata <= '0;
    else if (access) rdata <= rd ? mem[idx] : '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: valid/ready request, fixed LATENCY wait, valid/ready response.
// Optional fault-address capture enabled with `define DMEM_FAULT_CAPTURE_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  dmem_responder_if.slave   bus
`ifdef DMEM_FAULT_CAPTURE_EN
  ,
  input  logic              fault_clr,
  output logic              fault_seen,
  output logic [ADDR_W-1:0] fault_addr
`endif
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  wr_req_t           lat_req;

  logic [ADDR_W-1:0] acc_addr;
  wr_req_t           acc_req;
  logic [ADDR_W-1:0] word_c;
  logic              accept_c;
  logic              enter_resp_c;
  logic              err_c;

  // With zero latency the access uses the live request, otherwise the latched one.
  always_comb begin
    acc_addr = lat_addr;
    acc_req  = lat_req;
    if (LATENCY == 0) begin
      acc_addr = bus.req_addr;
      acc_req  = '{write: bus.req_write, wdata: bus.req_wdata, wstrb: bus.req_wstrb};
    end
  end

  assign accept_c     = (state == IDLE) && bus.req_valid && bus.req_ready;
  assign enter_resp_c = (accept_c && (LATENCY == 0)) ||
                        ((state == WAIT) && (cnt == CNT_W'(1)));
  assign word_c       = acc_addr >> OFFSET_BITS;
  assign err_c        = (acc_addr[OFFSET_BITS-1:0] != '0) || (word_c >= ADDR_W'(DEPTH));

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clock   (clock),
    .reset_n (reset_n),
    .access  (enter_resp_c),
    .rd      (!acc_req.write && !err_c),
    .wbe     ((acc_req.write && !err_c) ? acc_req.wstrb : '0),
    .idx     (word_c[IDX_W-1:0]),
    .wdata   (acc_req.wdata),
    .rdata   (bus.rsp_rdata)
  );

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_addr      <= '0;
      lat_req       <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (accept_c) begin
            lat_addr      <= bus.req_addr;
            lat_req       <= '{write: bus.req_write, wdata: bus.req_wdata, wstrb: bus.req_wstrb};
            cnt           <= CNT_W'(LATENCY);
            bus.req_ready <= 1'b0;
            state         <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (enter_resp_c) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= err_c;
      end
    end
  end

`ifdef DMEM_FAULT_CAPTURE_EN
  // First fault sticks until cleared; a fault coinciding with a clear is captured.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fault_seen <= 1'b0;
      fault_addr <= '0;
    end else if (enter_resp_c && err_c && (!fault_seen || fault_clr)) begin
      fault_seen <= 1'b1;
      fault_addr <= acc_addr;
    end else if (fault_clr) begin
      fault_seen <= 1'b0;
      fault_addr <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY=2 main instance, LATENCY=0 second instance).
// Also exercises fault capture when DMEM_FAULT_CAPTURE_EN is defined.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam int          NVEC  = 15;
  localparam int          NWORD = 16;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  dmem_responder_if #(.ADDR_W(64)) bus  ();
  dmem_responder_if #(.ADDR_W(64)) bus0 ();

`ifdef DMEM_FAULT_CAPTURE_EN
  logic        fault_clr, fault_seen, f0_seen;
  logic [63:0] fault_addr, f0_addr;
`endif

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .ADDR_W(64)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef DMEM_FAULT_CAPTURE_EN
    ,
    .fault_clr  (fault_clr),
    .fault_seen (fault_seen),
    .fault_addr (fault_addr)
`endif
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0), .ADDR_W(64)) u_dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
`ifdef DMEM_FAULT_CAPTURE_EN
    ,
    .fault_clr  (1'b0),
    .fault_seen (f0_seen),
    .fault_addr (f0_addr)
`endif
  );

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          hold;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] mref [NWORD];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One full transaction on the main instance; called and returns at a falling edge.
  task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                     input logic [7:0] s, input int hold,
                     input logic [63:0] exp_rd, input logic exp_e);
    int n;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clock);
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 40) begin
      chk("busy_req_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clock);
      n++;
    end
    chk("latency", 64'(n), 64'(LAT + 1));
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("rsp_err", 64'(bus.rsp_err), 64'(exp_e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_err", 64'(bus.rsp_err), 64'(exp_e));
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 64'(bus.rsp_valid), 64'd0);
    chk("ready_back", 64'(bus.req_ready), 64'd1);
  endtask

  // Reference model: error rule and byte-masked update from plain arithmetic.
  function automatic logic model_err(input logic [63:0] a);
    return ((a % 64'd8) != 64'd0) || ((a / 64'd8) >= 64'(DEPTH));
  endfunction

  function automatic logic [63:0] strb_mask(input logic [7:0] s);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) if (s[b]) m = m | (64'hFF << (8 * b));
    return m;
  endfunction

  vec_t vecs [NVEC];

  initial begin
    logic        w, e;
    logic [63:0] a, d, exp_rd, m;
    logic [7:0]  s;
    int          kind, wi, k, cyc, last;
    logic        w0 [4];
    logic [63:0] a0 [4];
    logic [63:0] r0 [4];
    logic        e0 [4];

    vecs[0]  = '{1'b1, 64'h8,    64'h1F,                  8'hFF, 0, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 64'h8,    64'h0,                   8'h00, 5, 64'h1F, 1'b0};
    vecs[2]  = '{1'b1, 64'h10,   64'hFFFFFFFF_FFFFFFFF,   8'hFF, 0, 64'h0, 1'b0};
    vecs[3]  = '{1'b1, 64'h10,   64'hAAAAAAAA_55555555,   8'h0F, 1, 64'h0, 1'b0};
    vecs[4]  = '{1'b0, 64'h10,   64'h0,                   8'hFF, 0, 64'hFFFFFFFF_55555555, 1'b0};
    vecs[5]  = '{1'b1, 64'h12,   64'h0,                   8'hFF, 0, 64'h0, 1'b1};
    vecs[6]  = '{1'b0, 64'h2000, 64'h0,                   8'h00, 2, 64'h0, 1'b1};
    vecs[7]  = '{1'b0, 64'h10,   64'h0,                   8'h00, 0, 64'hFFFFFFFF_55555555, 1'b0};
    vecs[8]  = '{1'b1, 64'h18,   64'h12345678_9ABCDEF0,   8'hFF, 0, 64'h0, 1'b0};
    vecs[9]  = '{1'b1, 64'h18,   64'hFFFFFFFF_FFFFFFFF,   8'h00, 0, 64'h0, 1'b0};
    vecs[10] = '{1'b0, 64'h18,   64'h0,                   8'h00, 0, 64'h12345678_9ABCDEF0, 1'b0};
    vecs[11] = '{1'b1, 64'h1FF8, 64'hCAFEF00D_00C0FFEE,   8'hFF, 0, 64'h0, 1'b0};
    vecs[12] = '{1'b0, 64'h1FF8, 64'h0,                   8'h00, 0, 64'hCAFEF00D_00C0FFEE, 1'b0};
    vecs[13] = '{1'b1, 64'h80000000_00000008, 64'h0,      8'hFF, 0, 64'h0, 1'b1};
    vecs[14] = '{1'b0, 64'h8,    64'h0,                   8'h00, 0, 64'h1F, 1'b0};

    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wstrb  = '0;
    bus.rsp_ready  = 1'b0;
    bus0.req_valid = 1'b0;
    bus0.req_write = 1'b0;
    bus0.req_addr  = '0;
    bus0.req_wdata = '0;
    bus0.req_wstrb = '0;
    bus0.rsp_ready = 1'b0;
`ifdef DMEM_FAULT_CAPTURE_EN
    fault_clr = 1'b0;
`endif
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_req_ready", 64'(bus.req_ready), 64'd1);

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      txn(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].hold,
          vecs[i].exp_rdata, vecs[i].exp_err);
`ifdef DMEM_FAULT_CAPTURE_EN
      if (i == 5 || i == 6) begin
        chk("fault_seen", 64'(fault_seen), 64'd1);
        chk("fault_addr", fault_addr, 64'h12);
      end
`endif
    end

`ifdef DMEM_FAULT_CAPTURE_EN
    fault_clr = 1'b1;
    @(negedge clock);
    fault_clr = 1'b0;
    chk("fault_clr_seen", 64'(fault_seen), 64'd0);
    chk("fault_clr_addr", fault_addr, 64'd0);
`endif

    // Reset during WAIT of a store: outputs clear at once, store is dropped
    txn(1'b0, 64'h8, 64'h0, 8'h00, 0, 64'h1F, 1'b0);
    bus.req_write = 1'b1;
    bus.req_addr  = 64'h18;
    bus.req_wdata = 64'hDEADBEEF_DEADBEEF;
    bus.req_wstrb = 8'hFF;
    bus.req_valid = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("midrst_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("midrst_rsp_err", 64'(bus.rsp_err), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    txn(1'b0, 64'h18, 64'h0, 8'h00, 0, 64'h12345678_9ABCDEF0, 1'b0);

    // Randomized traffic against the reference model
    for (int i = 0; i < NWORD; i++) begin
      mref[i] = {$urandom, $urandom};
      txn(1'b1, 64'(i) * 64'd8, mref[i], 8'hFF, 0, 64'h0, 1'b0);
    end
    for (int t = 0; t < 200; t++) begin
      kind = int'($urandom_range(0, 9));
      wi   = int'($urandom_range(0, NWORD - 1));
      if (kind < 7)       a = 64'(wi) * 64'd8;
      else if (kind == 7) a = 64'(wi) * 64'd8 + 64'($urandom_range(1, 7));
      else if (kind == 8) a = 64'(DEPTH + $urandom_range(0, 1000)) * 64'd8;
      else                a = (64'd1 << $urandom_range(13, 63)) + 64'(wi) * 64'd8;
      w = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      s = 8'($urandom_range(0, 255));
      e = model_err(a);
      exp_rd = (!e && !w) ? mref[a / 64'd8] : 64'h0;
      txn(w, a, d, s, int'($urandom_range(0, 3)), exp_rd, e);
      if (!e && w) begin
        m = strb_mask(s);
        mref[a / 64'd8] = (mref[a / 64'd8] & ~m) | (d & m);
      end
    end

    // Zero-latency instance: response one cycle after accept, accepts two cycles apart
    w0[0] = 1'b1; a0[0] = 64'h20; r0[0] = 64'h0;                  e0[0] = 1'b0;
    w0[1] = 1'b0; a0[1] = 64'h20; r0[1] = 64'h01234567_89ABCDEF;  e0[1] = 1'b0;
    w0[2] = 1'b0; a0[2] = 64'h21; r0[2] = 64'h0;                  e0[2] = 1'b1;
    w0[3] = 1'b0; a0[3] = 64'h20; r0[3] = 64'h01234567_89ABCDEF;  e0[3] = 1'b0;
    bus0.rsp_ready = 1'b1;
    k = 0;
    cyc = 0;
    last = -100;
    while (k < 4 && cyc < 60) begin
      bus0.req_write = w0[k];
      bus0.req_addr  = a0[k];
      bus0.req_wdata = 64'h01234567_89ABCDEF;
      bus0.req_wstrb = 8'hFF;
      bus0.req_valid = 1'b1;
      if (bus0.req_ready) begin
        if (k > 0) chk("lat0_gap_ge2", 64'(cyc - last >= 2), 64'd1);
        last = cyc;
        @(negedge clock);
        cyc++;
        chk("lat0_rsp_valid", 64'(bus0.rsp_valid), 64'd1);
        chk("lat0_rsp_rdata", bus0.rsp_rdata, r0[k]);
        chk("lat0_rsp_err", 64'(bus0.rsp_err), 64'(e0[k]));
        chk("lat0_busy", 64'(bus0.req_ready), 64'd0);
        bus0.req_valid = 1'b0;
        k++;
      end
      @(negedge clock);
      cyc++;
    end
    chk("lat0_all_accepted", 64'(k), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target that services the load/store requests the pipeline's MEM stage issues.
- Replaces the datapath's combinational data-memory array with a word-organised 64-bit memory.
- Uses a valid/ready request channel, a fixed programmable access latency, and a valid/ready response channel.
- Checks alignment and range; a faulting access returns an error response and does not touch memory.

Parameters:
- DEPTH, 1024, number of 64-bit words; index = req_addr >> 3
- LATENCY, 2, wait cycles between acceptance and response (0..15)
- ADDR_W, 64, request address width

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  64  store data
- req_wstrb  in  8  byte enables for stores; bit i selects bits [8i+7:8i]; ignored for loads
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  64  load data; 0 for stores and errors
- rsp_err  out  1  access faulted (misaligned or out of range)

Behaviour:
- Reset (reset_n low, async): state=IDLE, req_ready=0 while asserted then 1 in IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Memory array is not reset; contents persist.
- FSM: IDLE -> WAIT -> RESP -> IDLE.
- IDLE: req_ready=1. A request is accepted on the edge where req_valid & req_ready. The block latches write, addr, wdata and wstrb, and loads the counter with LATENCY.
  - LATENCY=0: goes directly to RESP.
  - Otherwise: goes to WAIT.
- WAIT: req_ready=0. Counter decrements each cycle; at count 1, moves to RESP.
- Memory access happens on the edge that enters RESP.
- Latency: rsp_valid rises exactly LATENCY+1 cycles after the accept edge.
- Error check on the latched request: err = (addr[2:0] != 0) | ((addr >> 3) >= DEPTH).
  - err=1: no read or write; rsp_rdata=0, rsp_err=1.
- Load: rsp_rdata = mem[idx], rsp_err=0.
- Store: mem[idx] bytes with wstrb=1 are updated; other bytes are unchanged; rsp_rdata=0, rsp_err=0. wstrb=0 is a legal no-op store.
- RESP: rsp_valid=1; rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid=0, return to IDLE.
  - A new request is accepted no earlier than the following cycle (no back-to-back overlap; one outstanding transaction max).
- Backpressure: rsp_ready held low keeps the block in RESP indefinitely; req_ready stays 0.
- Requester must hold the req_* signals stable while req_valid=1 and req_ready=0.
- Reset mid-operation: the in-flight transaction is dropped.
  - A store whose RESP edge has not yet occurred must not modify memory.
  - A store already committed stays committed.
- Address bits above what DEPTH needs only participate in the range check.

Optional Feature:
- Macro: DMEM_FAULT_CAPTURE_EN.
- Defined: adds ports fault_seen (out, 1) and fault_addr (out, ADDR_W), plus fault_clr (in, 1).
  - On the first errored access, the block sets fault_seen=1 and captures its address. Later faults do not overwrite the capture until fault_clr.
  - fault_clr=1 clears fault_seen and fault_addr to 0 on the next edge. A fault on the same cycle as fault_clr wins: it is captured.
  - Reset clears both.
- Undefined: ports and registers are absent; error reporting is via rsp_err only.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - word-size constants (WORD_BYTES=8, OFFSET_BITS=3)
  - helper function for byte-merge of wdata under wstrb
- One sub-module dmem_array: synchronous word RAM with per-byte write enable and registered read, instantiated by the FSM top. The fault-capture logic stays in the top.

Test Plan:
- Load with LATENCY=2, mem[1]=0x1F: request load at addr 0x8, rsp_ready=1 -> rsp_valid high exactly 3 cycles after accept, rsp_rdata=0x1F, rsp_err=0.
- Store with wstrb=0x0F, data 0xAAAAAAAA_55555555 to addr 0x10 over mem[2]=0xFFFFFFFF_FFFFFFFF, then load addr 0x10 -> rsp_rdata=0xFFFFFFFF_55555555.
- Misaligned store to addr 0x12, then out-of-range load to addr 0x2000 (DEPTH=1024) -> both rsp_err=1, rsp_rdata=0; mem[2] unchanged. With DMEM_FAULT_CAPTURE_EN: fault_addr=0x12, fault_seen=1.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; accept occurs only after the handshake completes.
- Reset mid-operation: pulse reset_n low during WAIT of a store to addr 0x18 -> all outputs at reset values immediately (async); a subsequent load of 0x18 returns the old value.
- LATENCY=0 build: load accepted at cycle T -> rsp_valid at T+1. Back-to-back requests -> each accept separated by at least 2 cycles.
